uart_autobaud: RTL and testbench

Baud-rate detector for the UART receive path. It measures a host-sent 0x55 ('U') sync character on the serial line and produces the 16x-oversampling `divisor` that the UART transceiver consumes. It sits between the `uart_rx` pad and the transceiver's `divisor` input, alongside the CSR-programmed divisor, and runs in the system clock domain.

---
 rtl/uart_autobaud_if.sv | 29 ++
 rtl/uart_autobaud.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_autobaud_if.sv
// uart_autobaud_if: serial-line and result bundle for the auto-baud detector.
// The slave modport is the detector; the master modport is whoever drives
// the line and the arm pulse and consumes the measured divisor.
interface uart_autobaud_if;
   logic        uart_rx;
   logic        arm;
   logic [15:0] divisor;
   logic        lock;
   logic        busy;
   logic        error;

   modport master (
      output uart_rx,
      output arm,
      input  divisor,
      input  lock,
      input  busy,
      input  error
   );

   modport slave (
      input  uart_rx,
      input  arm,
      output divisor,
      output lock,
      output busy,
      output error
   );
endinterface

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync character on uart_rx and produces the
// 16x-oversampling divisor (clocks per 1/16 bit) for the UART transceiver.
// The span from the start-bit falling edge to the 5th falling edge is eight
// bit times; divisor = round((span) / 128).
//
// Optional feature: define UART_AUTOBAUD_CHECK_EN to compile in an
// interval-consistency check (each of I2..I4 within 12.5% of I1). It adds
// one pipeline cycle before the result is published.
//
// CNT_W sets the width of the total/interval counters (23 in production,
// must not exceed 23); the timeout fires when the total counter saturates.
module uart_autobaud #(
   parameter logic [15:0] DEFAULT_DIV = 16'd54,
   parameter int unsigned CNT_W       = 23
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   uart_autobaud_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_HIGH  = 3'd1,
      WAIT_START = 3'd2,
      MEASURE    = 3'd3,
      DONE       = 3'd4,
      CHECK      = 3'd5,
      FAIL       = 3'd6
   } state_t;

   state_t           state_r;
   state_t           state_s;

   logic             sync1_r;
   logic             sync2_r;
   logic             sync3_r;
   logic             fe_s;

   logic [4:0]       high_cnt_r;
   logic [2:0]       edge_cnt_r;
   logic [CNT_W-1:0] total_r;
   logic [CNT_W-1:0] ival_r;

   logic             high_done_s;
   logic             fifth_fe_s;
   logic             sat_s;
   logic [23:0]      sum_s;
   logic [16:0]      q_s;
   logic             q_ok_s;

   logic [15:0]      divisor_r;
   logic             lock_r;
   logic             busy_r;
   logic             error_r;

   // Two-flop synchronizer plus a history flop for falling-edge detection.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         sync3_r <= 1'b1;
      end else begin
         sync1_r <= bus.uart_rx;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   assign fe_s        = sync3_r & ~sync2_r;
   assign high_done_s = sync2_r && (high_cnt_r == 5'd15);
   assign fifth_fe_s  = fe_s && (edge_cnt_r == 3'd4);
   assign sat_s       = (total_r == CNT_MAX);

   // sum = total + 1 is eight bit times in clocks; +64 then >>7 rounds half up.
   assign sum_s  = 24'(total_r) + 24'd1;
   assign q_s    = 17'((sum_s + 24'd64) >> 7);
   assign q_ok_s = (q_s != 17'd0) && (q_s[16] == 1'b0);

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; arm restarts from any state and wins over everything.
   always_comb begin
      state_s = state_r;
      if (bus.arm) begin
         state_s = WAIT_HIGH;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            WAIT_HIGH: begin
               if (high_done_s) begin
                  state_s = WAIT_START;
               end else begin
                  state_s = WAIT_HIGH;
               end
            end
            WAIT_START: begin
               if (fe_s) begin
                  state_s = MEASURE;
               end else begin
                  state_s = WAIT_START;
               end
            end
            MEASURE: begin
               if (sat_s) begin
                  state_s = FAIL;
               end else if (fifth_fe_s) begin
                  state_s = DONE;
               end else begin
                  state_s = MEASURE;
               end
            end
            DONE: begin
`ifdef UART_AUTOBAUD_CHECK_EN
               state_s = CHECK;
`else
               if (q_ok_s) begin
                  state_s = IDLE;
               end else begin
                  state_s = FAIL;
               end
`endif
            end
            CHECK: begin
               state_s = IDLE;
            end
            FAIL: begin
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // Idle-high qualifier, edge counter and the total/interval counters.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         high_cnt_r <= 5'd0;
         edge_cnt_r <= 3'd0;
         total_r    <= CNT_ZERO;
         ival_r     <= CNT_ZERO;
      end else if (bus.arm) begin
         high_cnt_r <= 5'd0;
         edge_cnt_r <= 3'd0;
         total_r    <= CNT_ZERO;
         ival_r     <= CNT_ZERO;
      end else begin
         case (state_r)
            WAIT_HIGH: begin
               if (sync2_r) begin
                  high_cnt_r <= high_cnt_r + 5'd1;
               end else begin
                  high_cnt_r <= 5'd0;
               end
            end
            WAIT_START: begin
               if (fe_s) begin
                  total_r    <= CNT_ZERO;
                  ival_r     <= CNT_ZERO;
                  edge_cnt_r <= 3'd1;
               end
            end
            MEASURE: begin
               if (fe_s) begin
                  edge_cnt_r <= edge_cnt_r + 3'd1;
                  ival_r     <= CNT_ZERO;
               end else begin
                  ival_r     <= ival_r + CNT_ONE;
               end
               // total freezes on the closing edge so DONE sees exactly 8 bits - 1.
               if (!sat_s && !fifth_fe_s) begin
                  total_r <= total_r + CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef UART_AUTOBAUD_CHECK_EN
   logic [CNT_W-1:0] iv1_r;
   logic [CNT_W-1:0] iv2_r;
   logic [CNT_W-1:0] iv3_r;
   logic [CNT_W-1:0] iv4_r;
   logic             pass_r;
   logic [15:0]      q_hold_r;

   function automatic logic dev_too_big(input logic [CNT_W-1:0] ik,
                                        input logic [CNT_W-1:0] i1);
      logic [CNT_W-1:0] diff;
      if (ik >= i1) begin
         diff = ik - i1;
      end else begin
         diff = i1 - ik;
      end
      return (diff > (i1 >> 3));
   endfunction

   // Latch each closed interval (edge cycle included), then judge them in DONE.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         iv1_r    <= CNT_ZERO;
         iv2_r    <= CNT_ZERO;
         iv3_r    <= CNT_ZERO;
         iv4_r    <= CNT_ZERO;
         pass_r   <= 1'b0;
         q_hold_r <= 16'd0;
      end else begin
         if ((state_r == MEASURE) && fe_s && !bus.arm) begin
            case (edge_cnt_r)
               3'd1:    iv1_r <= ival_r + CNT_ONE;
               3'd2:    iv2_r <= ival_r + CNT_ONE;
               3'd3:    iv3_r <= ival_r + CNT_ONE;
               3'd4:    iv4_r <= ival_r + CNT_ONE;
               default: begin
               end
            endcase
         end
         if (state_r == DONE) begin
            q_hold_r <= q_s[15:0];
            pass_r   <= q_ok_s && !dev_too_big(iv2_r, iv1_r)
                               && !dev_too_big(iv3_r, iv1_r)
                               && !dev_too_big(iv4_r, iv1_r);
         end
      end
   end
`endif

   // Published results: divisor only moves on a successful measurement.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         divisor_r <= DEFAULT_DIV;
         lock_r    <= 1'b0;
         busy_r    <= 1'b0;
         error_r   <= 1'b0;
      end else if (bus.arm) begin
         lock_r  <= 1'b0;
         error_r <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         case (state_r)
`ifdef UART_AUTOBAUD_CHECK_EN
            CHECK: begin
               busy_r <= 1'b0;
               if (pass_r) begin
                  divisor_r <= q_hold_r;
                  lock_r    <= 1'b1;
               end else begin
                  error_r   <= 1'b1;
               end
            end
`else
            DONE: begin
               if (q_ok_s) begin
                  divisor_r <= q_s[15:0];
                  lock_r    <= 1'b1;
                  busy_r    <= 1'b0;
               end
            end
`endif
            FAIL: begin
               error_r <= 1'b1;
               busy_r  <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.divisor = divisor_r;
   assign bus.lock    = lock_r;
   assign bus.busy    = busy_r;
   assign bus.error   = error_r;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed 0x55 frames with hand-computed divisors. The
// stimulus thread queues the expected result of each measurement; a monitor
// thread pops and compares whenever busy falls (a measurement finishing).
// The counter width is reduced to 14 bits so the timeout case stays short.
module tb_uart_autobaud;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   uart_autobaud_if bus ();

   uart_autobaud #(
      .DEFAULT_DIV (16'd54),
      .CNT_W       (14)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      string       name;
      logic [15:0] div;
      logic        lock;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic push_exp(input string name, input logic [15:0] div, input logic lock, input logic err);
      exp_t e;
      e.name = name;
      e.div  = div;
      e.lock = lock;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // One-cycle arm pulse; busy must be high on the following cycle.
   task automatic do_arm(input string name);
      @(negedge sys_clk);
      bus.arm = 1'b1;
      @(negedge sys_clk);
      bus.arm = 1'b0;
      check({name, "_busy_after_arm"}, 32'(bus.busy), 32'd1);
   endtask

   // 0x55 LSB first: start 0, 1,0,1,0,1,0,1,0. b3 is the length of data bit 3.
   // The trailing bit 7 is cut short and the stop bit follows; both are ignored.
   task automatic send_55(input int b, input int b3);
      bus.uart_rx = 1'b0; tick(b);
      bus.uart_rx = 1'b1; tick(b);
      bus.uart_rx = 1'b0; tick(b);
      bus.uart_rx = 1'b1; tick(b);
      bus.uart_rx = 1'b0; tick(b3);
      bus.uart_rx = 1'b1; tick(b);
      bus.uart_rx = 1'b0; tick(b);
      bus.uart_rx = 1'b1; tick(b);
      bus.uart_rx = 1'b0; tick(32);
      bus.uart_rx = 1'b1; tick(4);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (bus.busy && (k < budget)) begin
         @(negedge sys_clk);
         k++;
      end
      if (bus.busy) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, budget);
      end
      tick(20);
   endtask

   task automatic measure(input string name, input int b, input int b3);
      do_arm(name);
      tick(20);
      send_55(b, b3);
      wait_idle(name, 400);
   endtask

   // Monitor: a falling busy (outside reset) is a finished measurement.
   initial begin
      logic prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n && prev_busy && !bus.busy) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: divisor %0d lock %0d error %0d with no expectation queued",
                        bus.divisor, bus.lock, bus.error);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_divisor"}, 32'(bus.divisor), 32'(e.div));
               check({e.name, "_lock"},    32'(bus.lock),    32'(e.lock));
               check({e.name, "_error"},   32'(bus.error),   32'(e.err));
            end
         end
         prev_busy = bus.busy;
      end
   end

   initial begin
      sys_rst_n   = 1'b0;
      bus.uart_rx = 1'b1;
      bus.arm     = 1'b0;
      tick(3);
      sys_rst_n = 1'b1;
      tick(2);
      check("reset_divisor", 32'(bus.divisor), 32'd54);
      check("reset_lock",    32'(bus.lock),    32'd0);
      check("reset_busy",    32'(bus.busy),    32'd0);
      check("reset_error",   32'(bus.error),   32'd0);

      // sum 12800 -> (12800+64)>>7 = 100
      push_exp("b1600", 16'd100, 1'b1, 1'b0);
      measure("b1600", 1600, 1600);
      // sum 12864 -> 12928>>7 = 101 (exact half rounds up)
      push_exp("b1608", 16'd101, 1'b1, 1'b0);
      measure("b1608", 1608, 1608);
      // sum 12736 -> 12800>>7 = 100
      push_exp("b1592", 16'd100, 1'b1, 1'b0);
      measure("b1592", 1592, 1592);

      // bit 3 stretched: intervals 3200,3200,4000,3200; sum 13600 -> 106
`ifdef UART_AUTOBAUD_CHECK_EN
      push_exp("stretch", 16'd100, 1'b0, 1'b1);
`else
      push_exp("stretch", 16'd106, 1'b1, 1'b0);
`endif
      measure("stretch", 1600, 2400);

      // single falling edge then line stuck low: total saturates, divisor kept
`ifdef UART_AUTOBAUD_CHECK_EN
      push_exp("timeout", 16'd100, 1'b0, 1'b1);
`else
      push_exp("timeout", 16'd106, 1'b0, 1'b1);
`endif
      do_arm("timeout");
      tick(20);
      bus.uart_rx = 1'b0;
      wait_idle("timeout", 20000);
      bus.uart_rx = 1'b1;
      tick(20);

      // re-arm in the middle of a measurement, then a clean frame: 6464>>7 = 50
      push_exp("restart", 16'd50, 1'b1, 1'b0);
      do_arm("restart_first");
      tick(20);
      bus.uart_rx = 1'b0; tick(800);
      bus.uart_rx = 1'b1; tick(800);
      bus.uart_rx = 1'b0; tick(400);
      check("restart_busy_mid", 32'(bus.busy), 32'd1);
      bus.uart_rx = 1'b1;
      do_arm("restart_second");
      tick(20);
      send_55(800, 800);
      wait_idle("restart", 400);

      // asynchronous reset in the middle of a measurement
      do_arm("midreset");
      tick(20);
      bus.uart_rx = 1'b0; tick(800);
      bus.uart_rx = 1'b1; tick(300);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("midreset_divisor", 32'(bus.divisor), 32'd54);
      check("midreset_busy",    32'(bus.busy),    32'd0);
      check("midreset_lock",    32'(bus.lock),    32'd0);
      check("midreset_error",   32'(bus.error),   32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tick(10);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
